// File: rtl/lane_issue_ctrl_pkg.sv
// lane_issue_ctrl_pkg: shared sizes and types for the lane issue controller.
// Sizes come from PARALLEL_ORDER / REG_ADDR_WIDTH / REG_DATA_WIDTH when defined.
`ifndef PARALLEL_ORDER
`define PARALLEL_ORDER 2
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 4
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 8
`endif
package issue_pkg;
   localparam int P  = `PARALLEL_ORDER;
   localparam int AW = `REG_ADDR_WIDTH;
   localparam int DW = `REG_DATA_WIDTH;
   typedef enum logic {OP_LOAD = 1'b0, OP_MUL = 1'b1} op_e;
   typedef struct packed {
      op_e           op;
      logic [AW-1:0] rd;
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic [DW-1:0] imm;
   } instr_t;
   typedef struct packed {
      logic          valid;
      logic [AW-1:0] rd;
   } wb_slot_t;
endpackage

// File: rtl/lane_issue_ctrl_unit.sv
// lane_issue_unit: one lane's instruction queue, register scoreboard, hazard check and write-back shifter.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_instr accept side;
// r_valid/r_addr1/r_addr2 read controls; w_valid/w_sel/w_addr/w_data write controls; busy.
module lane_issue_unit
   import issue_pkg::*;
#(
   parameter int QDEPTH = 4,
   parameter int WB_LAT = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  instr_t        in_instr,
   output logic          r_valid,
   output logic [AW-1:0] r_addr1,
   output logic [AW-1:0] r_addr2,
   output logic          w_valid,
   output logic          w_sel,
   output logic [AW-1:0] w_addr,
   output logic [DW-1:0] w_data,
   output logic          busy
);
   localparam int PW = $clog2(QDEPTH);
   localparam int NR = 1 << AW;
   instr_t                  mem_q [QDEPTH];
   instr_t                  mem_d [QDEPTH];
   logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PW:0]             cnt_q, cnt_d;
   logic [NR-1:0]           pend_q, pend_d;
   wb_slot_t [WB_LAT-1:0]   sr_q, sr_d;
   logic                    r_valid_q, r_valid_d, w_valid_q, w_valid_d, w_sel_q, w_sel_d;
   logic [AW-1:0]           r_addr1_q, r_addr1_d, r_addr2_q, r_addr2_d, w_addr_q, w_addr_d;
   logic [DW-1:0]           w_data_q, w_data_d;
   instr_t                  head;
   logic                    push, issue, is_mul, wb_next, sr_any;
   always_comb begin
      head     = mem_q[rptr_q];
      is_mul   = head.op == OP_MUL;
      // the last shifter slot is the MUL result that lands on the write port next cycle
      wb_next  = sr_q[WB_LAT-1].valid;
      in_ready = cnt_q != (PW+1)'(QDEPTH);
      push     = in_valid && in_ready;
      issue    = cnt_q != '0 && (is_mul ? !(pend_q[head.rs1] || pend_q[head.rs2] || pend_q[head.rd])
                                        : !pend_q[head.rd] && !wb_next);
      mem_d = mem_q;
      if (push) mem_d[wptr_q] = in_instr;
      wptr_d = wptr_q + PW'(push);
      rptr_d = rptr_q + PW'(issue);
      cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(issue);
      // a register stays pending through its write-back cycle
      pend_d = pend_q;
      if (w_valid_q && w_sel_q) pend_d[w_addr_q] = 1'b0;
      if (issue && is_mul) pend_d[head.rd] = 1'b1;
      sr_d[0] = '{valid: issue && is_mul, rd: head.rd};
      for (int k = 1; k < WB_LAT; k++) sr_d[k] = sr_q[k-1];
      sr_any = 1'b0;
      for (int k = 0; k < WB_LAT; k++) sr_any = sr_any | sr_q[k].valid;
      r_valid_d = issue && is_mul;
      r_addr1_d = r_valid_d ? head.rs1 : r_addr1_q;
      r_addr2_d = r_valid_d ? head.rs2 : r_addr2_q;
      w_valid_d = wb_next || (issue && !is_mul);
      w_sel_d   = wb_next;
      w_addr_d  = wb_next ? sr_q[WB_LAT-1].rd : (issue && !is_mul) ? head.rd : w_addr_q;
      w_data_d  = (issue && !is_mul) ? head.imm : w_data_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < QDEPTH; k++) mem_q[k] <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
         pend_q    <= '0;
         sr_q      <= '0;
         r_valid_q <= 1'b0;
         r_addr1_q <= '0;
         r_addr2_q <= '0;
         w_valid_q <= 1'b0;
         w_sel_q   <= 1'b0;
         w_addr_q  <= '0;
         w_data_q  <= '0;
      end else begin
         mem_q     <= mem_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         sr_q      <= sr_d;
         r_valid_q <= r_valid_d;
         r_addr1_q <= r_addr1_d;
         r_addr2_q <= r_addr2_d;
         w_valid_q <= w_valid_d;
         w_sel_q   <= w_sel_d;
         w_addr_q  <= w_addr_d;
         w_data_q  <= w_data_d;
      end
   end
   assign r_valid = r_valid_q;
   assign r_addr1 = r_addr1_q;
   assign r_addr2 = r_addr2_q;
   assign w_valid = w_valid_q;
   assign w_sel   = w_sel_q;
   assign w_addr  = w_addr_q;
   assign w_data  = w_data_q;
   assign busy    = cnt_q != '0 || sr_any || pend_q != '0;
endmodule

// File: rtl/lane_issue_ctrl.sv
// lane_issue_ctrl: P independent LOAD/MUL issue lanes feeding the register-file/multiplier stage.
// Ports: clk, rst_n (async active-low); per lane in_valid/in_ready/in_instr;
// r_valid1/2, r_addr1/2 read controls; w_valid, w_sel, w_addr, w_data write controls; busy.
module lane_issue_ctrl
   import issue_pkg::*;
#(
   parameter int QDEPTH = 4,
   parameter int WB_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [P-1:0]         in_valid,
   output logic [P-1:0]         in_ready,
   input  instr_t [P-1:0]       in_instr,
   output logic [P-1:0]         r_valid1,
   output logic [P-1:0]         r_valid2,
   output logic [P-1:0][AW-1:0] r_addr1,
   output logic [P-1:0][AW-1:0] r_addr2,
   output logic [P-1:0]         w_valid,
   output logic [P-1:0]         w_sel,
   output logic [P-1:0][AW-1:0] w_addr,
   output logic [P-1:0][DW-1:0] w_data,
   output logic [P-1:0]         busy
);
   logic [P-1:0] r_valid;
   assign r_valid1 = r_valid;
   assign r_valid2 = r_valid;
   for (genvar i = 0; i < P; i++) begin : g_lane
      lane_issue_unit #(.QDEPTH(QDEPTH), .WB_LAT(WB_LAT)) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (in_valid[i]),
         .in_ready (in_ready[i]),
         .in_instr (in_instr[i]),
         .r_valid  (r_valid[i]),
         .r_addr1  (r_addr1[i]),
         .r_addr2  (r_addr2[i]),
         .w_valid  (w_valid[i]),
         .w_sel    (w_sel[i]),
         .w_addr   (w_addr[i]),
         .w_data   (w_data[i]),
         .busy     (busy[i])
      );
   end
endmodule

// File: tb/tb_lane_issue_ctrl.sv
// tb_lane_issue_ctrl: directed and random LOAD/MUL streams checked against a cycle-timeline reference model.
module tb_lane_issue_ctrl;
   import issue_pkg::*;
   localparam int QD = 4, WL = 2, NR = 1 << AW, CYC = 4096;
   typedef struct {
      instr_t ins;
      int     at;
   } stim_t;
   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [P-1:0]         in_valid = '0;
   instr_t [P-1:0]       in_instr = '0;
   logic [P-1:0]         in_ready, r_valid1, r_valid2, w_valid, w_sel, busy;
   logic [P-1:0][AW-1:0] r_addr1, r_addr2, w_addr;
   logic [P-1:0][DW-1:0] w_data;
   lane_issue_ctrl #(.QDEPTH(QD), .WB_LAT(WL)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .r_valid1(r_valid1), .r_valid2(r_valid2), .r_addr1(r_addr1), .r_addr2(r_addr2),
      .w_valid(w_valid), .w_sel(w_sel), .w_addr(w_addr), .w_data(w_data), .busy(busy)
   );
   always #5 clk = ~clk;
   int total = 0, bad = 0, cyc = 0, ps = 0;
   instr_t        mq [P][$];
   stim_t         src [P][$];
   int            pend_until [P][NR];
   bit            e_r [P][CYC];
   bit            e_w [P][CYC];
   bit            e_s [P][CYC];
   logic [AW-1:0] e_a1 [P][CYC];
   logic [AW-1:0] e_a2 [P][CYC];
   logic [AW-1:0] e_wa [P][CYC];
   logic [DW-1:0] e_wd [P][CYC];
   int first_r [P], last_r [P], first_w [P], last_w [P], nw [P], acc_last [P], first_nr [P];
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask
   function automatic instr_t mk(input op_e op, input int rd, input int rs1, input int rs2, input int imm);
      instr_t i;
      i.op  = op;
      i.rd  = AW'(rd);
      i.rs1 = AW'(rs1);
      i.rs2 = AW'(rs2);
      i.imm = DW'(imm);
      return i;
   endfunction
   task automatic add(input int l, input instr_t ins, input int at);
      stim_t s;
      s.ins = ins;
      s.at  = at;
      src[l].push_back(s);
   endtask
   task automatic clear_model();
      for (int l = 0; l < P; l++) begin
         mq[l].delete();
         src[l].delete();
         for (int r = 0; r < NR; r++) pend_until[l][r] = -1;
         for (int c = 0; c < CYC; c++) begin
            e_r[l][c] = 1'b0;
            e_w[l][c] = 1'b0;
         end
      end
   endtask
   task automatic reset_obs();
      ps = cyc;
      for (int l = 0; l < P; l++) begin
         first_r[l] = -1; last_r[l] = -1; first_w[l] = -1; last_w[l] = -1;
         nw[l] = 0; acc_last[l] = -1; first_nr[l] = -1;
      end
   endtask
   // one cycle: compare DUT against the timeline, advance the model, drive the next inputs
   task automatic step();
      if (cyc + WL + 2 >= CYC) begin
         $display("FAIL cycle_budget got=%0d limit=%0d", cyc, CYC);
         $fatal(1);
      end
      for (int l = 0; l < P; l++) begin
         bit ready, busy_m, wbn, ok;
         instr_t h;
         ready  = mq[l].size() < QD;
         busy_m = mq[l].size() != 0;
         wbn    = 1'b0;
         for (int r = 0; r < NR; r++) begin
            busy_m |= pend_until[l][r] >= cyc;
            wbn    |= pend_until[l][r] == cyc + 1;
         end
         check("in_ready", 32'(in_ready[l]), 32'(ready));
         check("busy", 32'(busy[l]), 32'(busy_m));
         check("r_valid1", 32'(r_valid1[l]), 32'(e_r[l][cyc]));
         check("r_valid2", 32'(r_valid2[l]), 32'(e_r[l][cyc]));
         if (e_r[l][cyc]) begin
            check("r_addr1", 32'(r_addr1[l]), 32'(e_a1[l][cyc]));
            check("r_addr2", 32'(r_addr2[l]), 32'(e_a2[l][cyc]));
         end
         check("w_valid", 32'(w_valid[l]), 32'(e_w[l][cyc]));
         if (e_w[l][cyc]) begin
            check("w_sel", 32'(w_sel[l]), 32'(e_s[l][cyc]));
            check("w_addr", 32'(w_addr[l]), 32'(e_wa[l][cyc]));
            if (!e_s[l][cyc]) check("w_data", 32'(w_data[l]), 32'(e_wd[l][cyc]));
         end
         if (r_valid1[l]) begin
            if (first_r[l] < 0) first_r[l] = cyc - ps;
            last_r[l] = cyc - ps;
         end
         if (w_valid[l]) begin
            if (first_w[l] < 0) first_w[l] = cyc - ps;
            last_w[l] = cyc - ps;
            nw[l]++;
         end
         if (!in_ready[l] && first_nr[l] < 0) first_nr[l] = cyc - ps;
         if (mq[l].size() != 0) begin
            h  = mq[l][0];
            ok = h.op == OP_MUL ? (pend_until[l][h.rs1] < cyc && pend_until[l][h.rs2] < cyc && pend_until[l][h.rd] < cyc)
                                : (pend_until[l][h.rd] < cyc && !wbn);
            if (ok) begin
               void'(mq[l].pop_front());
               if (h.op == OP_MUL) begin
                  e_r[l][cyc+1]  = 1'b1;
                  e_a1[l][cyc+1] = h.rs1;
                  e_a2[l][cyc+1] = h.rs2;
                  pend_until[l][h.rd] = cyc + 1 + WL;
                  e_w[l][cyc+1+WL]  = 1'b1;
                  e_s[l][cyc+1+WL]  = 1'b1;
                  e_wa[l][cyc+1+WL] = h.rd;
               end else begin
                  e_w[l][cyc+1]  = 1'b1;
                  e_s[l][cyc+1]  = 1'b0;
                  e_wa[l][cyc+1] = h.rd;
                  e_wd[l][cyc+1] = h.imm;
               end
            end
         end
         in_valid[l] = src[l].size() != 0 && src[l][0].at <= cyc - ps;
         in_instr[l] = in_valid[l] ? src[l][0].ins : '0;
         if (in_valid[l] && in_ready[l]) acc_last[l] = cyc - ps;
         if (in_valid[l] && ready) begin
            mq[l].push_back(src[l][0].ins);
            void'(src[l].pop_front());
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask
   task automatic run_phase(input int budget);
      int n;
      bit idle;
      n = 0;
      reset_obs();
      do begin
         step();
         n++;
         idle = 1'b1;
         for (int l = 0; l < P; l++) begin
            idle &= src[l].size() == 0 && mq[l].size() == 0;
            for (int r = 0; r < NR; r++) idle &= pend_until[l][r] < cyc;
         end
      end while (!idle && n < budget);
      check("phase_done", 32'(idle), 32'd1);
      step();
      step();
   endtask
   task automatic check_reset_outputs();
      for (int l = 0; l < P; l++) begin
         check("rst_in_ready", 32'(in_ready[l]), 32'd1);
         check("rst_busy", 32'(busy[l]), 32'd0);
         check("rst_r_valid", 32'({r_valid1[l], r_valid2[l]}), 32'd0);
         check("rst_r_addr", 32'({r_addr1[l], r_addr2[l]}), 32'd0);
         check("rst_w_valid", 32'({w_valid[l], w_sel[l]}), 32'd0);
         check("rst_w_addr", 32'(w_addr[l]), 32'd0);
         check("rst_w_data", 32'(w_data[l]), 32'd0);
      end
   endtask
   initial begin
      clear_model();
      #2;
      check_reset_outputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      reset_obs();
      // single LOAD
      add(0, mk(OP_LOAD, 1, 0, 0, 5), 0);
      run_phase(40);
      check("load_w_cycle", first_w[0], 2);
      // single MUL
      add(0, mk(OP_MUL, 3, 1, 2, 0), 0);
      run_phase(40);
      check("mul_r_cycle", first_r[0], 2);
      check("mul_w_cycle", first_w[0], 4);
      // RAW chain
      add(0, mk(OP_MUL, 3, 1, 2, 0), 0);
      add(0, mk(OP_MUL, 4, 3, 3, 0), 0);
      run_phase(40);
      check("raw_first_r", first_r[0], 2);
      check("raw_second_r", last_r[0], 6);
      // write-port collision
      add(0, mk(OP_MUL, 3, 1, 2, 0), 0);
      add(0, mk(OP_LOAD, 5, 0, 0, 8'h5a), 2);
      run_phase(40);
      check("col_load_cycle", last_w[0], 5);
      check("col_writes", nw[0], 2);
      // WAW
      add(0, mk(OP_MUL, 3, 1, 2, 0), 0);
      add(0, mk(OP_LOAD, 3, 0, 0, 7), 0);
      run_phase(40);
      check("waw_load_cycle", last_w[0], 6);
      // full queue on lane 0 with an independent stream on lane 1
      add(0, mk(OP_MUL, 3, 1, 2, 0), 0);
      add(0, mk(OP_MUL, 4, 3, 3, 0), 0);
      for (int k = 0; k < 4; k++) add(0, mk(OP_LOAD, 6 + k, 0, 0, 16 + k), 0);
      for (int k = 0; k < 6; k++) add(1, mk(k == 2 ? OP_MUL : OP_LOAD, 1 + k, 1, 2, 32 + k), 0);
      run_phase(60);
      check("full_not_ready", first_nr[0], 5);
      check("full_last_accept", acc_last[0], 6);
      // random streams
      for (int l = 0; l < P; l++) begin
         int at;
         at = 0;
         for (int k = 0; k < 150; k++) begin
            at += $urandom_range(0, 2);
            add(l, mk(op_e'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 255)), at);
         end
      end
      run_phase(2000);
      // reset while a MUL is in flight
      reset_obs();
      add(0, mk(OP_MUL, 3, 1, 2, 0), 0);
      step();
      step();
      step();
      check("inflight_r_cycle", first_r[0], 2);
      in_valid = '0;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      clear_model();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc++;
      reset_obs();
      for (int k = 0; k < 8; k++) step();
      check("rst_no_wb", nw[0], 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
